sdram_arb: RTL and testbench
============================

SDRAM_ARB -- requirements
Module: sdram_arb

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- AW, 25, address width.
- DW, 8, data width.

REQ-002 Ports SHALL be, one per line: name  direction  width  meaning. Clock and reset come first.
- clk  in  1  single clock; every flop SHALL be on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- vfd_rd  in  1  compositor read strobe; sampled only while vfd_rdy=1.
- vfd_addr  in  AW  compositor read address; sampled with vfd_rd.
- vfd_data  out  DW  read data; valid from the cycle vfd_rdy rises until the next accepted read.
- vfd_rdy  out  1  compositor may advance and issue; drives the compositor's rdy input.
- ld_wr  in  1  loader write strobe; sampled only while ld_busy=0.
- ld_addr  in  AW  loader write address.
- ld_data  in  DW  loader write data.
- ld_busy  out  1  loader write pending or in flight.
- mem_req  out  1  one-cycle request pulse to the SDRAM controller.
- mem_we  out  1  1=write, 0=read; stable from mem_req until mem_ack.
- mem_addr  out  AW  access address; stable from mem_req until mem_ack.
- mem_din  out  DW  write data; stable from mem_req until mem_ack.
- mem_dout  in  DW  read data; valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle completion pulse.

Function
REQ-003 Capture: when vfd_rd=1 and vfd_rdy=1 at an edge, the block SHALL latch vfd_addr, set pending_v, and drive vfd_rdy=0 from the next cycle.

REQ-004 Capture: when ld_wr=1 and ld_busy=0 at an edge, the block SHALL latch ld_addr and ld_data, set pending_l, and drive ld_busy=1 from the next cycle.

REQ-005 State machine states SHALL be IDLE, BUSY_V and BUSY_L.
- IDLE goes to BUSY_x when one or more pendings are set; the winner is chosen per REQ-006.
- BUSY_x returns to IDLE on mem_ack.

REQ-006 Arbitration: with both pendings set in IDLE, the loader SHALL win (fixed priority). REQ-015 modifies this rule.

REQ-007 Issue: mem_req SHALL be high for exactly the first cycle of BUSY_x.
- mem_we, mem_addr and mem_din SHALL be loaded on IDLE exit.
- These three signals SHALL hold their values until the cycle after mem_ack.

REQ-008 Completion in BUSY_V: on mem_ack the block SHALL register mem_dout into vfd_data, clear pending_v, and drive vfd_rdy=1 from the next cycle.

REQ-009 Completion in BUSY_L: on mem_ack the block SHALL clear pending_l and drive ld_busy=0 from the next cycle.

REQ-010 Latency: minimum time from an accepted vfd_rd to vfd_rdy=1 SHALL be 3 cycles plus the controller's req-to-ack latency, when no loader access is in flight.

REQ-011 Boundary conditions:
- A mem_ack received in IDLE SHALL be ignored.
- A strobe arriving while its port is busy or not ready SHALL be ignored.
- A capture coinciding with a mem_ack SHALL be accepted only if that port's ready/busy condition held at that edge.
- A new pending on one port SHALL NOT disturb an access already in flight.

REQ-012 There SHALL be at most one outstanding memory access at any time.

Reset
REQ-013 While rst_n=0, asynchronously, the block SHALL set:
- state=IDLE, pending_v=0, pending_l=0;
- vfd_rdy=1, ld_busy=0;
- mem_req=0, mem_we=0, mem_addr=0, mem_din=0, vfd_data=0;
- round-robin pointer=loader-last.

REQ-014 Reset asserted mid-access SHALL abandon that access. After release, a late mem_ack SHALL be ignored per REQ-011.

Configuration
REQ-015 With SDRAM_ARB_RR_EN defined, contention SHALL be resolved round-robin: the port not granted last SHALL win. Without the macro, fixed loader priority (REQ-006) SHALL apply and no pointer flop SHALL exist.

Structure
REQ-016 Package sdram_arb_pkg SHALL hold AW/DW defaults and the state enum (IDLE, BUSY_V, BUSY_L).

REQ-017 Winner selection (fixed or round-robin) SHALL live in a sub-module named arb_pick. It SHALL be combinational, with inputs pending_v, pending_l and last_grant, and output grant_l.

Verification
REQ-018 Directed scenarios the bench SHALL cover, one per line: stimulus -> required response.
- Single read: vfd_rd with vfd_addr=0x4B000, ack 2 cycles after req, mem_dout=0xA5 -> one mem_req with mem_we=0, addr 0x4B000; vfd_data=0xA5; vfd_rdy high 5 cycles after strobe.
- Single write: ld_wr with addr 0x10, data 0x3C -> one mem_req with mem_we=1, addr 0x10, din 0x3C; ld_busy low the cycle after ack.
- Contention: vfd_rd and ld_wr in the same cycle -> loader granted first; read issued after loader ack. With SDRAM_ARB_RR_EN, a second contention grants vfd.
- Stability: ack held off 20 cycles -> mem_addr, mem_we and mem_din unchanged throughout; mem_req high exactly 1 cycle.
- Stray and ignored events: mem_ack in IDLE, and vfd_rd while vfd_rdy=0 -> no state change, no extra mem_req.
- Reset mid-access: rst_n low during BUSY_V -> all outputs at reset values immediately; a late ack after release is ignored.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sdram_arb_pkg
// Shared definitions for the SDRAM arbiter slice:
//   - default address / data widths
//   - arbiter FSM state encoding
//   - grant encoding used by the round-robin pointer (last_grant)
// Optional feature macro used by this slice: SDRAM_ARB_RR_EN
// -----------------------------------------------------------------------------
package sdram_arb_pkg;

  localparam int AW_DEF = 25;  // default address width
  localparam int DW_DEF = 8;   // default data width

  // Arbiter FSM: idle, or one access in flight for the compositor (V) or
  // the loader (L). Only one access can ever be outstanding.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_V = 2'd1,
    BUSY_L = 2'd2
  } state_e;

  // Encoding of a grant / last_grant bit: 1 = loader, 0 = compositor.
  localparam logic GRANT_V = 1'b0;
  localparam logic GRANT_L = 1'b1;

endpackage : sdram_arb_pkg

// File: rtl/sdram_arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational winner selection between the compositor read port and the
// loader write port.
//
// Ports:
//   pending_v  in  1  compositor read request waiting
//   pending_l  in  1  loader write request waiting
//   last_grant in  1  port granted most recently (1 = loader, 0 = compositor)
//   grant_l    out 1  1 = loader wins, 0 = compositor wins (only meaningful
//                     when at least one pending is set)
//
// Configuration:
//   SDRAM_ARB_RR_EN undefined : fixed priority, loader always wins contention;
//                               last_grant is not used.
//   SDRAM_ARB_RR_EN defined   : round-robin, the port not granted last wins
//                               contention.
// -----------------------------------------------------------------------------
module arb_pick
  import sdram_arb_pkg::*;
(
  input  logic pending_v,
  input  logic pending_l,
  input  logic last_grant,
  output logic grant_l
);

`ifdef SDRAM_ARB_RR_EN
  always_comb begin
    grant_l = pending_l;
    if (pending_v && pending_l) begin
      // Contention: hand the slot to whichever port did not get the last one.
      grant_l = (last_grant == GRANT_L) ? GRANT_V : GRANT_L;
    end
  end
`else
  // Fixed priority: any loader request beats a compositor request.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant_l = pending_l;
  end
`endif

endmodule : arb_pick

// File: rtl/sdram_arb.sv
// -----------------------------------------------------------------------------
// sdram_arb
// Two-port arbiter in front of a single-access SDRAM controller. A compositor
// (read-only, vfd_* port) and a loader (write-only, ld_* port) each post one
// request at a time; the arbiter issues them to the controller one at a time
// as a one-cycle mem_req pulse and completes them on mem_ack.
//
// Parameters:
//   AW  address width (default 25)
//   DW  data width    (default 8)
//
// Ports:
//   clk       in   1   clock, all flops on rising edge
//   rst_n     in   1   asynchronous active-low reset
//   vfd_rd    in   1   compositor read strobe, taken only while vfd_rdy=1
//   vfd_addr  in   AW  compositor read address
//   vfd_data  out  DW  last read data, held until the next accepted read
//   vfd_rdy   out  1   compositor port free
//   ld_wr     in   1   loader write strobe, taken only while ld_busy=0
//   ld_addr   in   AW  loader write address
//   ld_data   in   DW  loader write data
//   ld_busy   out  1   loader write pending or in flight
//   mem_req   out  1   one-cycle request pulse to the controller
//   mem_we    out  1   1 = write, 0 = read; held until the cycle after mem_ack
//   mem_addr  out  AW  access address; held until the cycle after mem_ack
//   mem_din   out  DW  write data; held until the cycle after mem_ack
//   mem_dout  in   DW  read data, valid with mem_ack
//   mem_ack   in   1   one-cycle completion pulse
//
// Configuration:
//   SDRAM_ARB_RR_EN  when defined, contention is resolved round-robin and a
//                    last-grant pointer flop exists; otherwise the loader has
//                    fixed priority and there is no pointer.
// -----------------------------------------------------------------------------
module sdram_arb
  import sdram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vfd_rd,
  input  logic [AW-1:0] vfd_addr,
  output logic [DW-1:0] vfd_data,
  output logic          vfd_rdy,
  input  logic          ld_wr,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          ld_busy,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  input  logic          mem_ack
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e        state_q,    state_d;
  logic          pend_v_q,   pend_v_d;    // compositor request waiting/in flight
  logic          pend_l_q,   pend_l_d;    // loader request waiting/in flight
  logic [AW-1:0] addr_v_q,   addr_v_d;    // captured compositor address
  logic [AW-1:0] addr_l_q,   addr_l_d;    // captured loader address
  logic [DW-1:0] data_l_q,   data_l_d;    // captured loader data
  logic          req_q,      req_d;
  logic          we_q,       we_d;
  logic [AW-1:0] maddr_q,    maddr_d;
  logic [DW-1:0] din_q,      din_d;
  logic [DW-1:0] rdata_q,    rdata_d;

  logic          cap_v;
  logic          cap_l;
  logic          grant_l;
  logic          last_grant;

`ifdef SDRAM_ARB_RR_EN
  logic          last_l_q,   last_l_d;    // 1 = loader was granted last
  assign last_grant = last_l_q;
`else
  // No pointer in fixed-priority builds; the picker ignores this input.
  assign last_grant = GRANT_L;
`endif

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
  arb_pick u_pick (
    .pending_v  (pend_v_q),
    .pending_l  (pend_l_q),
    .last_grant (last_grant),
    .grant_l    (grant_l)
  );

  // A strobe is taken only while its own port is free at that edge; the
  // port's free flag is simply the complement of its pending bit, so a
  // strobe coinciding with that port's own mem_ack is still refused.
  assign cap_v = vfd_rd && !pend_v_q;
  assign cap_l = ld_wr  && !pend_l_q;

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    pend_v_d = pend_v_q;
    pend_l_d = pend_l_q;
    addr_v_d = addr_v_q;
    addr_l_d = addr_l_q;
    data_l_d = data_l_q;
    req_d    = 1'b0;          // mem_req is a single-cycle pulse
    we_d     = we_q;
    maddr_d  = maddr_q;
    din_d    = din_q;
    rdata_d  = rdata_q;
`ifdef SDRAM_ARB_RR_EN
    last_l_d = last_l_q;
`endif

    unique case (state_q)
      IDLE: begin
        // A mem_ack seen here is stray (or a leftover from an access that a
        // reset abandoned) and is deliberately ignored.
        if (pend_v_q || pend_l_q) begin
          state_d = grant_l ? BUSY_L : BUSY_V;
          req_d   = 1'b1;
          we_d    = grant_l;
          maddr_d = grant_l ? addr_l_q : addr_v_q;
          din_d   = data_l_q;
`ifdef SDRAM_ARB_RR_EN
          last_l_d = grant_l;
`endif
        end
      end

      BUSY_V: begin
        if (mem_ack) begin
          state_d  = IDLE;
          rdata_d  = mem_dout;
          pend_v_d = 1'b0;
        end
      end

      BUSY_L: begin
        if (mem_ack) begin
          state_d  = IDLE;
          pend_l_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Captures never collide with the clears above: a clear needs the
    // pending bit set, a capture needs it clear.
    if (cap_v) begin
      pend_v_d = 1'b1;
      addr_v_d = vfd_addr;
    end
    if (cap_l) begin
      pend_l_d = 1'b1;
      addr_l_d = ld_addr;
      data_l_d = ld_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pend_v_q <= 1'b0;
      pend_l_q <= 1'b0;
      addr_v_q <= '0;
      addr_l_q <= '0;
      data_l_q <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      din_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      pend_v_q <= pend_v_d;
      pend_l_q <= pend_l_d;
      addr_v_q <= addr_v_d;
      addr_l_q <= addr_l_d;
      data_l_q <= data_l_d;
      req_q    <= req_d;
      we_q     <= we_d;
      maddr_q  <= maddr_d;
      din_q    <= din_d;
      rdata_q  <= rdata_d;
    end
  end

`ifdef SDRAM_ARB_RR_EN
  // Pointer starts as "loader granted last", so the compositor wins the
  // first contention after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_l_q <= GRANT_L;
    end else begin
      last_l_q <= last_l_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign vfd_rdy  = !pend_v_q;
  assign ld_busy  = pend_l_q;
  assign vfd_data = rdata_q;
  assign mem_req  = req_q;
  assign mem_we   = we_q;
  assign mem_addr = maddr_q;
  assign mem_din  = din_q;

endmodule : sdram_arb

// File: tb/tb_sdram_arb.sv
// -----------------------------------------------------------------------------
// tb_sdram_arb
// Self-checking bench for sdram_arb. The bench plays the SDRAM controller
// (a sparse memory plus a programmable req-to-ack delay) and keeps a
// transaction-level model of the two ports: which requests are waiting,
// which one is in flight, and what each read must return.
// Honors SDRAM_ARB_RR_EN for the expected arbitration order.
// -----------------------------------------------------------------------------
module tb_sdram_arb;

  localparam int AW = 25;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vfd_rd;
  logic [AW-1:0] vfd_addr;
  logic [DW-1:0] vfd_data;
  logic          vfd_rdy;
  logic          ld_wr;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_busy;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic          mem_ack;

  always #5 clk = ~clk;

  sdram_arb #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .vfd_rd   (vfd_rd),
    .vfd_addr (vfd_addr),
    .vfd_data (vfd_data),
    .vfd_rdy  (vfd_rdy),
    .ld_wr    (ld_wr),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_busy  (ld_busy),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .mem_ack  (mem_ack)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory / controller model ----------------
  logic [DW-1:0] sdram [logic [AW-1:0]];
  int            ack_lat   = 2;
  int            ack_cnt   = 0;
  logic          stray_ack = 1'b0;

  function automatic logic [DW-1:0] sdram_rd(input logic [AW-1:0] a);
    return sdram.exists(a) ? sdram[a] : '0;
  endfunction

  // ---------------- port-level reference model ----------------
  logic          m_idle, m_pv, m_pl, m_infl_l, m_last_l;
  logic [AW-1:0] m_vaddr, m_laddr;
  logic [DW-1:0] m_ldata, m_vdata;
  logic          cap_we;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_din;

  // issued-access log (what the DUT actually put on the bus)
  logic          iss_we   [$];
  logic [AW-1:0] iss_addr [$];
  logic [DW-1:0] iss_din  [$];

  task automatic model_reset();
    m_idle = 1'b1; m_pv = 1'b0; m_pl = 1'b0; m_infl_l = 1'b0;
    m_last_l = 1'b1; m_vdata = '0;
    m_vaddr = '0; m_laddr = '0; m_ldata = '0;
  endtask

  function automatic logic pick_loader();
`ifdef SDRAM_ARB_RR_EN
    if (m_pv && m_pl) return !m_last_l;
`endif
    return m_pl;
  endfunction

  task automatic clear_log();
    iss_we.delete(); iss_addr.delete(); iss_din.delete();
  endtask

  // One clock: apply the edge to the model, compare, then act as controller.
  task automatic tick();
    logic p_vrd, p_lwr, p_ack, p_rst;
    logic [AW-1:0] p_vaddr, p_laddr;
    logic [DW-1:0] p_ldata;
    logic exp_req, done, acc_v, acc_l, g_l;
    p_vrd = vfd_rd; p_vaddr = vfd_addr;
    p_lwr = ld_wr;  p_laddr = ld_addr; p_ldata = ld_data;
    p_ack = mem_ack; p_rst = rst_n;
    @(posedge clk); #1;
    if (mem_req) begin
      iss_we.push_back(mem_we); iss_addr.push_back(mem_addr); iss_din.push_back(mem_din);
      $display("[%0t] txn %s addr=%07h din=%02h", $time, mem_we ? "WR" : "RD", mem_addr, mem_din);
    end
    if (p_rst && rst_n) begin
      exp_req = 1'b0; done = 1'b0;
      acc_v = p_vrd && !m_pv;
      acc_l = p_lwr && !m_pl;
      if (m_idle && (m_pv || m_pl)) begin
        exp_req  = 1'b1;
        g_l      = pick_loader();
        m_last_l = g_l;
        m_idle   = 1'b0;
        m_infl_l = g_l;
        cap_we   = g_l;
        cap_addr = g_l ? m_laddr : m_vaddr;
        cap_din  = m_ldata;
      end else if (!m_idle && p_ack) begin
        done = 1'b1;
        if (m_infl_l) begin
          sdram[m_laddr] = m_ldata;
          m_pl = 1'b0;
        end else begin
          m_vdata = sdram_rd(m_vaddr);
          m_pv = 1'b0;
        end
        m_idle = 1'b1;
      end
      if (acc_v) begin m_pv = 1'b1; m_vaddr = p_vaddr; end
      if (acc_l) begin m_pl = 1'b1; m_laddr = p_laddr; m_ldata = p_ldata; end

      check("mem_req", mem_req, exp_req);
      if (!m_idle || done) begin
        check("hold_we", mem_we, cap_we);
        check("hold_addr", mem_addr, cap_addr);
        if (cap_we) check("hold_din", mem_din, cap_din);
      end
      check("vfd_rdy", vfd_rdy, !m_pv);
      check("ld_busy", ld_busy, m_pl);
      check("vfd_data", vfd_data, m_vdata);
    end
    // controller behaviour
    mem_ack = 1'b0;
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) begin
        mem_ack  = 1'b1;
        mem_dout = sdram_rd(mem_addr);
      end
    end
    if (mem_req) begin
      ack_cnt = ack_lat;
    end else if (stray_ack && ack_cnt == 0 && m_idle && !mem_ack && rst_n) begin
      mem_ack   = 1'b1;
      mem_dout  = DW'($urandom);
      stray_ack = 1'b0;
    end
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (!(m_idle && !m_pv && !m_pl) && n < max_cycles) begin
      tick();
      n++;
    end
    if (!(m_idle && !m_pv && !m_pl)) check("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vfd_rdy"}, vfd_rdy, 1'b1);
    check({tag, "_ld_busy"}, ld_busy, 1'b0);
    check({tag, "_mem_req"}, mem_req, 1'b0);
    check({tag, "_mem_we"}, mem_we, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, '0);
    check({tag, "_mem_din"}, mem_din, '0);
    check({tag, "_vfd_data"}, vfd_data, '0);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 15));
    if ($urandom_range(0, 1) == 1) a = a | 25'h1F00000;
    return a;
  endfunction

  initial begin
    int n;
    rst_n = 1'b1; vfd_rd = 1'b0; vfd_addr = '0; ld_wr = 1'b0; ld_addr = '0;
    ld_data = '0; mem_ack = 1'b0; mem_dout = '0;
    model_reset();
    cap_we = 1'b0; cap_addr = '0; cap_din = '0;

    // ---- reset state ----
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();

    // ---- single read ----
    sdram[25'h4B000] = 8'hA5;
    ack_lat = 2; clear_log();
    vfd_rd = 1'b1; vfd_addr = 25'h4B000;
    tick();
    vfd_rd = 1'b0; vfd_addr = rand_addr();
    n = 1;
    while (!vfd_rdy && n < 50) begin tick(); n++; end
    check("rd_latency", n, 5);
    check("rd_data", vfd_data, 8'hA5);
    check("rd_nreq", iss_we.size(), 1);
    if (iss_we.size() > 0) begin
      check("rd_we", iss_we[0], 1'b0);
      check("rd_addr", iss_addr[0], 25'h4B000);
    end
    wait_idle(20); tick();

    // ---- single write ----
    clear_log();
    ld_wr = 1'b1; ld_addr = 25'h10; ld_data = 8'h3C;
    tick();
    ld_wr = 1'b0; ld_data = 8'hFF;
    n = 1;
    while (ld_busy && n < 50) begin tick(); n++; end
    check("wr_latency", n, 5);
    check("wr_nreq", iss_we.size(), 1);
    if (iss_we.size() > 0) begin
      check("wr_we", iss_we[0], 1'b1);
      check("wr_addr", iss_addr[0], 25'h10);
      check("wr_din", iss_din[0], 8'h3C);
    end
    tick();

    // ---- contention x2 (read address equals write address) ----
    for (int c = 0; c < 2; c++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      a = (c == 0) ? 25'h21 : 25'h30;
      d = (c == 0) ? 8'h77 : 8'h5A;
      clear_log();
      vfd_rd = 1'b1; vfd_addr = a;
      ld_wr = 1'b1; ld_addr = a; ld_data = d;
      tick();
      vfd_rd = 1'b0; ld_wr = 1'b0;
      wait_idle(40);
      check("cont_nreq", iss_we.size(), 2);
      if (iss_we.size() == 2) begin
`ifdef SDRAM_ARB_RR_EN
        check("cont_first_we", iss_we[0], 1'b0);
        check("cont_second_we", iss_we[1], 1'b1);
`else
        check("cont_first_we", iss_we[0], 1'b1);
        check("cont_second_we", iss_we[1], 1'b0);
        check("cont_rd_data", vfd_data, d);
`endif
      end
      tick();
    end

    // ---- stability with a slow controller ----
    clear_log();
    ack_lat = 20;
    ld_wr = 1'b1; ld_addr = 25'h1ABCDE; ld_data = 8'hC3;
    tick();
    ld_wr = 1'b0; ld_addr = '0; ld_data = '0;
    n = 0;
    while (iss_we.size() == 0 && n < 10) begin tick(); n++; end
    check("stab_issued", iss_we.size(), 1);
    for (int i = 0; i < 19; i++) begin
      tick();
      check("stab_addr", mem_addr, 25'h1ABCDE);
      check("stab_we", mem_we, 1'b1);
      check("stab_din", mem_din, 8'hC3);
      check("stab_req_low", mem_req, 1'b0);
    end
    wait_idle(40);
    check("stab_nreq", iss_we.size(), 1);
    tick();

    // ---- stray ack in IDLE, ignored read strobe while busy ----
    clear_log();
    ack_lat = 2;
    stray_ack = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("stray_nreq", iss_we.size(), 0);
    check("stray_vfd_data", vfd_data, m_vdata);
    ack_lat = 6;
    sdram[25'h40] = 8'h9E;
    vfd_rd = 1'b1; vfd_addr = 25'h40;
    tick();
    vfd_rd = 1'b0;
    tick(); tick();
    vfd_rd = 1'b1; vfd_addr = 25'h41;
    tick();
    vfd_rd = 1'b0;
    wait_idle(40);
    check("ign_nreq", iss_we.size(), 1);
    if (iss_addr.size() > 0) check("ign_addr", iss_addr[0], 25'h40);
    check("ign_data", vfd_data, 8'h9E);
    tick();

    // ---- reset mid-access, late ack afterwards ----
    clear_log();
    ack_lat = 5;
    vfd_rd = 1'b1; vfd_addr = 25'h4B000;
    tick();
    vfd_rd = 1'b0;
    tick(); tick();
    check("rst_busy_rdy", vfd_rdy, 1'b0);
    rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("midrst_nreq", iss_we.size(), 1);
    check("midrst_vfd_data", vfd_data, 8'h00);

    // ---- randomized traffic ----
    for (int i = 0; i < 600; i++) begin
      vfd_rd    = ($urandom_range(0, 3) == 0);
      vfd_addr  = rand_addr();
      ld_wr     = ($urandom_range(0, 4) == 0);
      ld_addr   = rand_addr();
      ld_data   = DW'($urandom);
      ack_lat   = $urandom_range(1, 4);
      if ($urandom_range(0, 15) == 0) stray_ack = 1'b1;
      tick();
    end
    vfd_rd = 1'b0; ld_wr = 1'b0; stray_ack = 1'b0;
    wait_idle(100);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sdram_arb
